// File: rtl/dmem_if.sv
// dmem_if: shared data-memory bus between the core array and the memory responder.
interface dmem_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [NUM_CORES-1:0] memread;
  logic [NUM_CORES-1:0] memwr;
  logic [NUM_CORES*ADDR_W-1:0] dmaddr;
  logic [NUM_CORES*DATA_W-1:0] dout;
  logic [NUM_CORES*DATA_W-1:0] din;
  logic [NUM_CORES-1:0] ack;
  logic busy;
  modport master (output memread, memwr, dmaddr, dout, input din, ack, busy);
  modport slave (input memread, memwr, dmaddr, dout, output din, ack, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: round-robin arbitrated single-port RAM serving NUM_CORES cores,
// one three-cycle transaction (IDLE grant, ACCESS, RESP ack) at a time.
module dmem_responder #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 12
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus
);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [NUM_CORES-1:0] req;
  logic [CW-1:0] rr_ptr, g, win;
  logic found, op_wr;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NUM_CORES*DATA_W-1:0] din_r;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  int idx;
  assign req = bus.memread | bus.memwr;
  assign bus.busy = state != IDLE;
  assign bus.din = din_r;
  // first requester at or after rr_ptr, wrapping around the core ring
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!found && req[idx]) begin
        win = CW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    bus.ack = '0;
    state_n = state == IDLE ? (found ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    bus.ack = state == RESP ? NUM_CORES'(1) << g : '0;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      g <= '0;
      op_wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rr_ptr <= '0;
      din_r <= '0;
    end else begin
      if (state == IDLE && found) begin
        g <= win;
        op_wr <= bus.memwr[win];
        addr <= bus.dmaddr[win*ADDR_W +: MEM_AW];
        wdata <= bus.dout[win*DATA_W +: DATA_W];
      end
      if (state == ACCESS && !op_wr) din_r[g*DATA_W +: DATA_W] <= mem[addr];
      if (state == RESP) rr_ptr <= (g == CW'(NUM_CORES - 1)) ? '0 : g + 1'b1;
    end
  end
  // RAM has no reset; a reset at the ACCESS edge suppresses the write
  always_ff @(posedge clk) if (!rst && state == ACCESS && op_wr) mem[addr] <= wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, hand sequences and a randomized run
// against a transaction-level model of the shared memory responder.
module tb_dmem_responder;
  localparam int NC = 4, DW = 16, AW = 16, MAW = 12, DEPTH = 1 << MAW;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  dmem_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();
  dmem_responder #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  typedef struct {
    int core;
    bit rd;
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_din;
  } vec_t;
  vec_t vt[8];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ref_din [NC];
  logic [DW-1:0] rd_val, pd [NC];
  logic [AW-1:0] pa [NC];
  logic [NC*DW-1:0] saved, exp_bus;
  bit pend [NC], prd [NC], pwr [NC], rd_pend;
  int lat, rr, free_e, ack_e, ack_c, busy_to, w, r, k, key;
  int ord [6] = '{0, 2, 0, 2, 0, 2};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.memread[c] = rd;
    bus.memwr[c] = wr;
    bus.dmaddr[c*AW +: AW] = a;
    bus.dout[c*DW +: DW] = d;
  endtask
  task automatic drop(input int c);
    bus.memread[c] = 1'b0;
    bus.memwr[c] = 1'b0;
  endtask
  task automatic do_reset;
    for (int c = 0; c < NC; c++) drop(c);
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  // waits (bounded) for the next ACK, expects it on core c, then releases that core
  task automatic wait_ack(input int c, input string name, output int n);
    n = 1;
    tick();
    while (bus.ack == '0 && n < 30) begin
      tick();
      n++;
    end
    chk(name, 64'(bus.ack), 64'(1) << c);
    for (int i = 0; i < NC; i++) if (bus.ack[i]) drop(i);
    drop(c);
  endtask
  task automatic din_chk(input int c, input logic [DW-1:0] e, input string name);
    chk(name, 64'(bus.din[c*DW +: DW]), 64'(e));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.memread = '0;
    bus.memwr = '0;
    bus.dmaddr = '0;
    bus.dout = '0;
    vt[0] = '{0, 0, 1, 16'h0010, 16'hBEEF, 16'h0000};
    vt[1] = '{0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[2] = '{1, 1, 1, 16'h0005, 16'h1234, 16'h0000};
    vt[3] = '{1, 1, 0, 16'h0005, 16'h0000, 16'h1234};
    vt[4] = '{3, 0, 1, 16'h1003, 16'hA5A5, 16'h0000};
    vt[5] = '{2, 1, 0, 16'h0003, 16'h0000, 16'hA5A5};
    vt[6] = '{2, 0, 1, 16'h0003, 16'h5A5A, 16'hA5A5};
    vt[7] = '{2, 1, 0, 16'h0003, 16'h0000, 16'h5A5A};
    do_reset();
    chk("reset ack", 64'(bus.ack), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset din", 64'(bus.din), 64'(0));
    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].core, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
      wait_ack(vt[i].core, "vec ack", lat);
      chk("vec latency", 64'(lat), 64'(2));
      din_chk(vt[i].core, vt[i].exp_din, "vec din");
      tick();
      chk("vec idle busy", 64'(bus.busy), 64'(0));
      chk("vec idle ack", 64'(bus.ack), 64'(0));
    end
    do_reset();
    set_req(0, 1, 0, 16'h0010, 0);
    set_req(1, 1, 0, 16'h0005, 0);
    set_req(2, 1, 0, 16'h0003, 0);
    set_req(3, 1, 0, 16'h1003, 0);
    for (int i = 0; i < NC; i++) begin
      wait_ack(i, "rr ack", lat);
      chk("rr spacing", 64'(lat), 64'(i == 0 ? 2 : 3));
    end
    din_chk(0, 16'hBEEF, "rr din0");
    din_chk(1, 16'h1234, "rr din1");
    din_chk(2, 16'h5A5A, "rr din2");
    din_chk(3, 16'h5A5A, "rr din3");
    set_req(0, 1, 0, 16'h0005, 0);
    set_req(2, 1, 0, 16'h0010, 0);
    for (int i = 0; i < 6; i++) begin
      wait_ack(ord[i], "alt ack", lat);
      chk("alt spacing", 64'(lat), 64'(3));
      din_chk(ord[i], ord[i] == 0 ? 16'h1234 : 16'hBEEF, "alt din");
      if (ord[i] == 0) set_req(0, 1, 0, 16'h0005, 0);
      else set_req(2, 1, 0, 16'h0010, 0);
    end
    drop(0);
    drop(2);
    tick();
    tick();
    tick();
    set_req(2, 1, 0, 16'h0010, 0);
    tick();
    tick();
    chk("resp ack", 64'(bus.ack), 64'h4);
    din_chk(2, 16'hBEEF, "resp din2");
    rst = 1;
    drop(2);
    tick();
    chk("mid rst ack", 64'(bus.ack), 64'(0));
    chk("mid rst busy", 64'(bus.busy), 64'(0));
    chk("mid rst din", 64'(bus.din), 64'(0));
    rst = 0;
    set_req(1, 1, 0, 16'h0005, 0);
    set_req(3, 1, 0, 16'h0003, 0);
    wait_ack(1, "post rst first", lat);
    chk("post rst lat", 64'(lat), 64'(2));
    din_chk(1, 16'h1234, "post rst din1");
    wait_ack(3, "post rst second", lat);
    din_chk(3, 16'h5A5A, "post rst din3");
    tick();
    saved = bus.din;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle busy", 64'(bus.busy), 64'(0));
      chk("idle ack", 64'(bus.ack), 64'(0));
      chk("idle din", 64'(bus.din), 64'(saved));
    end
    do_reset();
    rr = 0;
    free_e = 1;
    ack_e = -10;
    ack_c = 0;
    busy_to = -10;
    rd_pend = 0;
    rd_val = '0;
    ref_mem.delete();
    for (int c = 0; c < NC; c++) begin
      ref_din[c] = '0;
      pend[c] = 0;
    end
    for (int e = 1; e <= 900; e++) begin
      for (int c = 0; c < NC; c++) begin
        if (!pend[c] && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 3);
          k = $urandom_range(0, 7);
          pa[c] = AW'(($urandom_range(0, 15) << 12) | (k * 37));
          pd[c] = DW'($urandom);
          prd[c] = r != 1;
          pwr[c] = r <= 1;
          if (!ref_mem.exists(int'(pa[c]) % DEPTH)) pwr[c] = 1;
          pend[c] = 1;
          set_req(c, prd[c], pwr[c], pa[c], pd[c]);
        end
      end
      // server model: idle server takes the first pending core at/after rr, busy 3 cycles
      w = -1;
      for (int j = 0; j < NC; j++) if (w < 0 && pend[(rr + j) % NC]) w = (rr + j) % NC;
      if (e >= free_e && w >= 0) begin
        key = int'(pa[w]) % DEPTH;
        rd_pend = !pwr[w];
        if (pwr[w]) ref_mem[key] = pd[w];
        else rd_val = ref_mem[key];
        ack_c = w;
        ack_e = e + 1;
        busy_to = e + 1;
        free_e = e + 3;
        rr = (w + 1) % NC;
      end
      tick();
      if (e == ack_e && rd_pend) ref_din[ack_c] = rd_val;
      for (int c = 0; c < NC; c++) exp_bus[c*DW +: DW] = ref_din[c];
      chk("rand ack", 64'(bus.ack), e == ack_e ? 64'(1) << ack_c : 64'(0));
      chk("rand busy", 64'(bus.busy), 64'(e <= busy_to));
      chk("rand din", 64'(bus.din), 64'(exp_bus));
      if (e == ack_e) begin
        pend[ack_c] = 0;
        drop(ack_c);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
